// File: rtl/my_associative_buffer_arbiter_pkg.sv
// my_associative_buffer_arbiter_pkg: buffer ctrl codes and arbiter FSM encodings
`ifndef MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH
`define MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH 3
`endif
package my_associative_buffer_arbiter_pkg;
  localparam int CTRL_W = `MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH;
  localparam logic [CTRL_W-1:0] CTRL_NOP  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] CTRL_CLR  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] CTRL_LOAD = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] CTRL_INCR = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] CTRL_DECR = CTRL_W'(4);
  localparam int STATE_W = 2;
  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_LOOKUP  = 2'd1;
  localparam logic [1:0] STATE_UPDATE  = 2'd2;
  localparam logic [1:0] STATE_RESPOND = 2'd3;
endpackage

// File: rtl/my_associative_buffer_arbiter_rr.sv
// my_round_robin_arbiter_2: 2-way combinational grant; MY_ASSOCIATIVE_BUFFER_ARBITER_PRIORITY_EN makes req0 win every tie
module my_round_robin_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
`ifdef MY_ASSOCIATIVE_BUFFER_ARBITER_PRIORITY_EN
  always_comb grant = req[0] ? 2'b01 : req;
`else
  always_comb grant = &req ? (last ? 2'b01 : 2'b10) : req;
`endif
endmodule

// File: rtl/my_associative_buffer_arbiter.sv
// my_associative_buffer_arbiter: serialises two requesters onto one associative buffer (lookup, optional update, respond);
// MY_ASSOCIATIVE_BUFFER_ARBITER_PRIORITY_EN swaps round-robin for fixed req0 priority.
module my_associative_buffer_arbiter
  import my_associative_buffer_arbiter_pkg::*;
#(
  parameter int CTRL_WIDTH = CTRL_W,
  parameter int KEY_WIDTH  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic [KEY_WIDTH-1:0]  req0_key,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  input  logic [KEY_WIDTH-1:0]  req1_key,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic [CTRL_WIDTH-1:0] buf_ctrl,
  output logic [KEY_WIDTH-1:0]  buf_key,
  output logic [DATA_WIDTH-1:0] buf_data,
  input  logic [DATA_WIDTH-1:0] buf_data_out,
  input  logic                  buf_data_valid
);
  localparam logic [CTRL_WIDTH-1:0] NOP = CTRL_WIDTH'(CTRL_NOP);
  logic [STATE_W-1:0]    state_q, state_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d, win_q, win_d, last_q;
  logic [1:0]            grant;
  logic                  accept;
  my_round_robin_arbiter_2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (grant)
  );
  // rst gates accept so no ready pulse escapes while reset is held
  assign accept = rst && state_q == STATE_IDLE && |grant;
  always_comb begin
    ctrl_d     = accept ? (grant[1] ? req1_ctrl : req0_ctrl) : ctrl_q;
    key_d      = accept ? (grant[1] ? req1_key : req0_key) : key_q;
    data_d     = accept ? (grant[1] ? req1_data : req0_data) : data_q;
    win_d      = accept ? grant[1] : win_q;
    rsp_data_d = state_q == STATE_LOOKUP ? buf_data_out : rsp_data_q;
    rsp_hit_d  = state_q == STATE_LOOKUP ? buf_data_valid : rsp_hit_q;
    state_d    = accept ? STATE_LOOKUP :
                 state_q == STATE_LOOKUP ? (ctrl_q != NOP ? STATE_UPDATE : STATE_RESPOND) :
                 state_q == STATE_UPDATE ? STATE_RESPOND : STATE_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= STATE_IDLE;
      ctrl_q     <= NOP;
      key_q      <= '0;
      data_q     <= '0;
      win_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_hit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      key_q      <= key_d;
      data_q     <= data_d;
      win_q      <= win_d;
      rsp_data_q <= rsp_data_d;
      rsp_hit_q  <= rsp_hit_d;
    end
  end
`ifdef MY_ASSOCIATIVE_BUFFER_ARBITER_PRIORITY_EN
  assign last_q = 1'b1;
`else
  logic last_d;
  always_comb last_d = accept ? grant[1] : last_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
`endif
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];
  assign req0_done  = state_q == STATE_RESPOND && !win_q;
  assign req1_done  = state_q == STATE_RESPOND && win_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_hit    = rsp_hit_q;
  assign buf_ctrl   = state_q == STATE_UPDATE ? ctrl_q : NOP;
  assign buf_key    = key_q;
  assign buf_data   = data_q;
endmodule
